// File: rtl/dir_pkg.sv
// Shared types and constants for the direction-register serial reader.
package dir_pkg;
  localparam int DIR_NUM    = 4;
  localparam int DIR_ADDR_W = 2;
  localparam int DIR_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } dir_state_e;
endpackage

// File: rtl/dir_shift_out.sv
// Load/shift-right register with bit counter and last-bit flag, LSB first.
// DIR_RD_PARITY_EN appends one even-parity bit after the data bits.
module dir_shift_out
  import dir_pkg::*;
#(
  parameter int DATA_W = DIR_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              bit_o,
  output logic              last_o
);
  localparam int CNT_W = $clog2(DATA_W + 2);

  logic [DATA_W-1:0] sh_q, sh_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sh_d  = data_i;
      cnt_d = '0;
    end else if (shift_i) begin
      sh_d  = sh_q >> 1;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef DIR_RD_PARITY_EN
  logic par_q;

  // Parity is taken from the word at load time, since sh_q is consumed by shifting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         par_q <= 1'b0;
    else if (load_i) par_q <= ^data_i;
  end

  assign last_o = (cnt_q == CNT_W'(DATA_W));
  assign bit_o  = last_o ? par_q : sh_q[0];
`else
  assign last_o = (cnt_q == CNT_W'(DATA_W - 1));
  assign bit_o  = sh_q[0];
`endif
endmodule

// File: rtl/dir_reg_reader.sv
// Captures one of four direction registers on a qualified strobe and serializes it LSB first.
// Optional DIR_RD_PARITY_EN adds a trailing even-parity bit (see dir_shift_out).
module dir_reg_reader
  import dir_pkg::*;
#(
  parameter int DATA_W  = DIR_DATA_W,
  parameter int DIR_NUM = dir_pkg::DIR_NUM
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DIR_ADDR_W-1:0]     addr_in,
  input  logic                      strob_in,
  input  logic                      choose_dir_reg,
  input  logic [DIR_NUM*DATA_W-1:0] dir_regs_in,
  output logic [DATA_W-1:0]         data_out,
  output logic                      ser_out,
  output logic                      ser_valid,
  output logic                      busy,
  output logic                      done
);
  dir_state_e        state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] sel_word;
  logic              accept, shift, bit_w, last_w;

  assign sel_word = dir_regs_in[addr_in*DATA_W +: DATA_W];

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    accept    = 1'b0;
    shift     = 1'b0;
    ser_valid = 1'b0;
    done      = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (strob_in && choose_dir_reg) begin
          accept  = 1'b1;
          data_d  = sel_word;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy      = 1'b1;
        ser_valid = 1'b1;
        shift     = 1'b1;
        if (last_w) state_d = ST_DONE;
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  dir_shift_out #(.DATA_W(DATA_W)) u_shift (
    .clk    (clk),
    .rst    (rst),
    .load_i (accept),
    .shift_i(shift),
    .data_i (sel_word),
    .bit_o  (bit_w),
    .last_o (last_w)
  );

  assign data_out = data_q;
  assign ser_out  = ser_valid & bit_w;
endmodule

// File: tb/tb_dir_reg_reader.sv
// Directed self-checking bench for dir_reg_reader; honours DIR_RD_PARITY_EN.
module tb_dir_reg_reader;
  import dir_pkg::*;

  localparam int DW = 8;
`ifdef DIR_RD_PARITY_EN
  localparam int NB = DW + 1;
`else
  localparam int NB = DW;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    addr_in;
  logic          strob_in, choose_dir_reg;
  logic [4*DW-1:0] dir_regs_in;
  logic [DW-1:0] data_out;
  logic          ser_out, ser_valid, busy, done;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  dir_reg_reader #(.DATA_W(DW), .DIR_NUM(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .addr_in       (addr_in),
    .strob_in      (strob_in),
    .choose_dir_reg(choose_dir_reg),
    .dir_regs_in   (dir_regs_in),
    .data_out      (data_out),
    .ser_out       (ser_out),
    .ser_valid     (ser_valid),
    .busy          (busy),
    .done          (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [1:0] a, input logic ch);
    addr_in = a; strob_in = 1'b1; choose_dir_reg = ch;
    step();
    strob_in = 1'b0; choose_dir_reg = 1'b0;
  endtask

  // Call right after an accepted request. mode 1: stray request at bit 2; mode 2: zero reg 2 at bit 0.
  task automatic check_xfer(input string nm, input logic [DW-1:0] w, input int mode);
    logic [NB-1:0] exp_bits;
    logic [NB-1:0] got;
    logic          vld_ok;
    got = '0; vld_ok = 1'b1;
`ifdef DIR_RD_PARITY_EN
    exp_bits = {^w, w};
`else
    exp_bits = w;
`endif
    total++;
    if (data_out !== w) $display("FAIL %s data_out got %h exp %h", nm, data_out, w);
    else pass_cnt++;
    for (int i = 0; i < NB; i++) begin
      if (ser_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) vld_ok = 1'b0;
      got[i] = ser_out;
      if (mode == 1 && i == 2) begin
        addr_in = 2'd1; strob_in = 1'b1; choose_dir_reg = 1'b1;
      end else begin
        strob_in = 1'b0; choose_dir_reg = 1'b0;
      end
      if (mode == 2 && i == 0) dir_regs_in[2*DW +: DW] = '0;
      step();
    end
    strob_in = 1'b0; choose_dir_reg = 1'b0;
    total++;
    if (!vld_ok) $display("FAIL %s valid/busy during shift not held", nm);
    else pass_cnt++;
    total++;
    if (got !== exp_bits) $display("FAIL %s serial bits got %h exp %h", nm, got, exp_bits);
    else pass_cnt++;
    total++;
    if (done !== 1'b1 || ser_valid !== 1'b0 || busy !== 1'b1 || ser_out !== 1'b0)
      $display("FAIL %s done cycle got done=%b vld=%b busy=%b ser=%b exp 1 0 1 0",
               nm, done, ser_valid, busy, ser_out);
    else pass_cnt++;
    step();
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || data_out !== w)
      $display("FAIL %s idle after done got done=%b busy=%b data=%h exp 0 0 %h",
               nm, done, busy, data_out, w);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; addr_in = '0; strob_in = 1'b0; choose_dir_reg = 1'b0;
    dir_regs_in = {8'h0F, 8'hA5, 8'h3C, 8'h81};
    step(); step();
    rst = 1'b0;
    step();
    total++;
    if (data_out !== 8'h00 || ser_out !== 1'b0 || ser_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset outputs got data=%h ser=%b vld=%b busy=%b done=%b exp all 0",
               data_out, ser_out, ser_valid, busy, done);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    request(2'd2, 1'b1);
    check_xfer("basic_a5", 8'hA5, 0);
    request(2'd0, 1'b1);
    check_xfer("basic_81", 8'h81, 0);
  endtask

  task automatic test_no_choose();
    logic ok;
    ok = 1'b1;
    request(2'd3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (busy !== 1'b0 || ser_valid !== 1'b0 || data_out !== 8'h81) ok = 1'b0;
      step();
    end
    total++;
    if (!ok) $display("FAIL no_choose busy=%b vld=%b data=%h exp 0 0 81", busy, ser_valid, data_out);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    request(2'd0, 1'b1);
    check_xfer("b2b_first", 8'h81, 1);
    request(2'd1, 1'b1);
    check_xfer("b2b_second", 8'h3C, 0);
  endtask

  task automatic test_mid_reset();
    request(2'd1, 1'b1);
    for (int i = 0; i < 3; i++) step();
    total++;
    if (ser_valid !== 1'b1 || ser_out !== 1'b1)
      $display("FAIL mid_rst bit3 got vld=%b ser=%b exp 1 1", ser_valid, ser_out);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    total++;
    if (data_out !== 8'h00 || ser_out !== 1'b0 || ser_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL mid_rst async got data=%h ser=%b vld=%b busy=%b done=%b exp all 0",
               data_out, ser_out, ser_valid, busy, done);
    else pass_cnt++;
    step();
    rst = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
        if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        step();
      end
      total++;
      if (seen) $display("FAIL mid_rst activity after abort got done/busy high exp 0");
      else pass_cnt++;
    end
    request(2'd3, 1'b1);
    check_xfer("after_rst_0f", 8'h0F, 0);
  endtask

  task automatic test_overwrite();
    request(2'd2, 1'b1);
    check_xfer("overwrite_a5", 8'hA5, 2);
    request(2'd2, 1'b1);
    check_xfer("reg2_zero", 8'h00, 0);
    dir_regs_in[2*DW +: DW] = 8'h01;
    request(2'd2, 1'b1);
    check_xfer("reg2_01", 8'h01, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_choose();
    test_back_to_back();
    test_mid_reset();
    test_overwrite();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dir_reg_reader.md
DIR_REG_READER -- requirements
Module: dir_reg_reader

Interface
REQ-001 Parameter DATA_W, default 8, width of each direction register and of the serial word.
REQ-002 Parameter DIR_NUM, default 4, number of direction registers (fixed at 4 by the 2-bit address).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 addr_in  input  2  direction register index for a read request.
REQ-006 strob_in  input  1  read request strobe, single-cycle.
REQ-007 choose_dir_reg  input  1  qualifies strob_in as a direction-register access.
REQ-008 dir_regs_in  input  DIR_NUM*DATA_W  packed register contents; register k occupies bits [k*DATA_W +: DATA_W].
REQ-009 data_out  output  DATA_W  parallel copy of the captured register.
REQ-010 ser_out  output  1  serial data, LSB first.
REQ-011 ser_valid  output  1  high while ser_out carries a valid bit.
REQ-012 busy  output  1  high from acceptance through the done cycle.
REQ-013 done  output  1  single-cycle end-of-transfer pulse.

Function
REQ-014 Request accepted when strob_in & choose_dir_reg are both high in IDLE; otherwise no effect.
REQ-015 FSM states: IDLE, SHIFT, DONE.
REQ-016 On acceptance: capture dir_regs_in slice addr_in into shift register and data_out; IDLE -> SHIFT next edge.
REQ-017 In SHIFT: ser_valid=1, ser_out = current LSB of shift register; shift right one bit per cycle; bit counter 0..DATA_W-1.
REQ-018 First serial bit appears the cycle after acceptance (latency 1).
REQ-019 SHIFT -> DONE after bit DATA_W-1 is presented; counter does not wrap within a transfer.
REQ-020 DONE: done=1, ser_valid=0, busy=1 for exactly one cycle; DONE -> IDLE unconditionally.
REQ-021 busy high in SHIFT and DONE; total busy duration DATA_W+1 cycles (no parity).
REQ-022 Requests arriving while busy are ignored, not queued; a request in the cycle after DONE (IDLE) is accepted.
REQ-023 Changes on dir_regs_in after capture do not affect the transfer in progress.
REQ-024 data_out holds the captured value until the next accepted request.
REQ-025 ser_out=0 whenever ser_valid=0.

Reset
REQ-026 rst asserted: state IDLE, counter 0, shift register 0, data_out 0, ser_out 0, ser_valid 0, busy 0, done 0, immediately, without waiting for clk.
REQ-027 rst mid-transfer aborts it; no done pulse; first request after rst release accepted normally.

Configuration
REQ-028 Macro DIR_RD_PARITY_EN defined: after bit DATA_W-1 one extra SHIFT cycle emits even parity of the captured word with ser_valid=1; busy lasts DATA_W+2 cycles.
REQ-029 Macro undefined: no parity cycle, no parity logic synthesized; timing per REQ-021.

Structure
REQ-030 Shared package dir_pkg holds the FSM state enum, DIR_NUM, DIR_ADDR_W=2 and default DATA_W.
REQ-031 One sub-module dir_shift_out: load/shift register with bit counter and last-bit flag; FSM and request qualification stay in dir_reg_reader.

Verification
REQ-032 Regs {0x81,0x3C,0xA5,0x0F}, addr=2, strob+choose one cycle -> data_out=0xA5; ser_out 1,0,1,0,0,1,0,1 over 8 valid cycles; done on 9th cycle after acceptance.
REQ-033 strob_in=1, choose_dir_reg=0 -> busy stays 0, no ser_valid, data_out unchanged.
REQ-034 Second request (addr=1) during SHIFT of addr=0 -> ignored; only 0x81 serialized; request one cycle after done -> 0x3C serialized.
REQ-035 rst asserted at 4th serial bit -> all outputs 0 same cycle, no done; subsequent addr=3 -> 0x0F sent complete.
REQ-036 Overwrite reg 2 to 0x00 one cycle after capture -> serial stream still 0xA5.
REQ-037 With DIR_RD_PARITY_EN, addr=2 (0xA5, four ones) -> 9th valid bit 0, done on 10th cycle; addr=0 (0x81) -> parity 0; reg value 0x01 -> parity 1.
